// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, oversampling ratio and the transmitter state encoding.
// The receiver and the FIFO instantiations consume the same defaults.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: pops one byte from the TX FIFO when idle and shifts it out LSB first
// as start / DBIT data / stop, timed by the shared 16x oversampling tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter must reach both the per-bit terminal and the stop-bit terminal.
  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    tx_done_tick = 1'b0;
    tx_d         = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = r_data;
        s_d     = '0;
        n_d     = '0;
        state_d = START;
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered from the next state so it changes with the state register.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the shift register is plain flops, so clearing it on reset costs nothing and keeps state deterministic.
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign rd      = (state_q == POP);
  assign tx_busy = (state_q != IDLE);
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: drives a small FIFO model and decodes the serial line
// frame by frame, for the default stop length and for SB_TICK=32.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       fifo_empty;
  logic       sel;
  logic [7:0] r_data;
  logic       empty1, empty2;
  logic       rd1, tx1, busy1, done1;
  logic       rd2, tx2, busy2, done2;
  logic       o_rd, o_tx, o_busy, o_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int div      = 1;
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  assign empty1 = sel ? 1'b1 : fifo_empty;
  assign empty2 = sel ? fifo_empty : 1'b1;
  assign o_rd   = sel ? rd2   : rd1;
  assign o_tx   = sel ? tx2   : tx1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .empty        (empty1),
    .r_data       (r_data),
    .rd           (rd1),
    .tx           (tx1),
    .tx_busy      (busy1),
    .tx_done_tick (done1)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32)) dut_sb32 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .empty        (empty2),
    .r_data       (r_data),
    .rd           (rd2),
    .tx           (tx2),
    .tx_busy      (busy2),
    .tx_done_tick (done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle and set that cycle's s_tick.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_tick = (div == 1) ? 1'b1 : ((cyc % div) == 0);
    #1;
  endtask

  task automatic wait_rd(input int budget, output int waited);
    waited = 0;
    while (o_rd !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  // Called on the POP cycle; follows the frame to the first IDLE cycle after it.
  task automatic frame_check(input logic [7:0] exp_byte, input int stop_ticks,
                             input int done_off_exp, input string tag);
    int seg, ticks, len, off, done_off, n_done;
    int bad_lvl, bad_rd, bad_busy, bad_done, bad_len;
    logic [7:0] dec, nxt;
    logic lvl, last;

    check({tag, "_rd"},     32'(o_rd),   32'd1);
    check({tag, "_pop_tx"}, 32'(o_tx),   32'd1);
    check({tag, "_pop_bsy"},32'(o_busy), 32'd1);
    nxt        = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    r_data     = ~exp_byte;
    tick();
    off    = 1;
    r_data = nxt;
    check({tag, "_load_rd"}, 32'(o_rd), 32'd0);
    check({tag, "_load_tx"}, 32'(o_tx), 32'd1);

    seg = 0; ticks = 0; len = 0; dec = '0; n_done = 0; done_off = -1;
    bad_lvl = 0; bad_rd = 0; bad_busy = 0; bad_done = 0; bad_len = 0;
    while (seg < 10 && off < 5000) begin
      tick();
      off++;
      len++;
      lvl = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : exp_byte[seg-1];
      if (o_tx !== lvl) bad_lvl++;
      if (len == 1 && seg >= 1 && seg <= 8) dec[seg-1] = o_tx;
      if (o_rd !== 1'b0) bad_rd++;
      if (o_busy !== 1'b1) bad_busy++;
      if (s_tick) ticks++;
      last = (seg == 9) && s_tick && (ticks == stop_ticks);
      if (o_done !== last) bad_done++;
      if (o_done === 1'b1) begin
        n_done++;
        done_off = off;
      end
      if (s_tick && ticks == ((seg == 9) ? stop_ticks : 16)) begin
        if (seg >= 1 && seg <= 8 && len != 16 * div) bad_len++;
        if (seg == 9 && len != stop_ticks * div) bad_len++;
        seg++;
        ticks = 0;
        len = 0;
      end
    end

    check({tag, "_complete"}, 32'(seg),      32'd10);
    check({tag, "_line"},     32'(bad_lvl),  32'd0);
    check({tag, "_byte"},     32'(dec),      32'(exp_byte));
    check({tag, "_no_rd"},    32'(bad_rd),   32'd0);
    check({tag, "_busy"},     32'(bad_busy), 32'd0);
    check({tag, "_done_pos"}, 32'(bad_done), 32'd0);
    check({tag, "_done_cnt"}, 32'(n_done),   32'd1);
    check({tag, "_bit_len"},  32'(bad_len),  32'd0);
    if (done_off_exp >= 0) check({tag, "_done_off"}, 32'(done_off), 32'(done_off_exp));

    tick();
    check({tag, "_idle_bsy"}, 32'(o_busy), 32'd0);
    check({tag, "_idle_tx"},  32'(o_tx),   32'd1);
    check({tag, "_idle_rd"},  32'(o_rd),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n_rd, n_dn;
    logic [7:0] lost;

    reset = 1'b1; s_tick = 1'b1; sel = 1'b0; r_data = '0; div = 1;
    fifo_q.push_back(8'hA5);
    fifo_empty = 1'b0;

    // Reset held with a non-empty FIFO: nothing may be popped.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_rd",   32'(o_rd),   32'd0);
      check("rst_tx",   32'(o_tx),   32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("rd_after_reset", 32'(o_rd), 32'd1);
    frame_check(8'hA5, 16, 161, "a5");

    n_rd = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_rd !== 1'b0) n_rd++;
    end
    check("empty_no_rd", 32'(n_rd), 32'd0);

    // Three queued bytes, back to back.
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    fifo_empty = 1'b0;
    wait_rd(10, w);
    check("q_latency", 32'(w), 32'd1);
    frame_check(8'h00, 16, 161, "q00");
    wait_rd(10, w);
    check("q_gap1", 32'(w), 32'd1);
    frame_check(8'hFF, 16, 161, "qff");
    wait_rd(10, w);
    check("q_gap2", 32'(w), 32'd1);
    frame_check(8'h3C, 16, 161, "q3c");
    n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_rd !== 1'b0) n_rd++;
    end
    check("q_no_extra_rd", 32'(n_rd), 32'd0);

    // Slow tick: one s_tick every 4 cycles, 64 cycles per bit.
    div = 4;
    fifo_q.push_back(8'h01);
    fifo_empty = 1'b0;
    wait_rd(10, w);
    check("div4_rd_seen", 32'(o_rd), 32'd1);
    frame_check(8'h01, 16, -1, "div4");
    div = 1;

    // Reset during data bit 3: the in-flight byte is dropped, the next frame pops afresh.
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h5A);
    fifo_empty = 1'b0;
    wait_rd(10, w);
    check("mid_rd_seen", 32'(o_rd), 32'd1);
    lost = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    tick();
    r_data = lost;
    n_dn = 0;
    for (int off = 2; off <= 70; off++) begin
      tick();
      if (o_done !== 1'b0) n_dn++;
    end
    check("mid_no_done",  32'(n_dn), 32'd0);
    check("mid_bit3_tx",  32'(o_tx), 32'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_tx",   32'(o_tx),   32'd1);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    wait_rd(5, w);
    check("mid_repop", 32'(w), 32'd1);
    frame_check(8'h5A, 16, 161, "after_rst");

    // 32-tick stop bit on the second instance.
    sel = 1'b1;
    fifo_q.push_back(8'h55);
    fifo_empty = 1'b0;
    wait_rd(10, w);
    check("sb32_latency", 32'(w), 32'd1);
    frame_check(8'h55, 32, 177, "sb32");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
